// File: rtl/anubis_theta_seq.sv
// Sequenced Anubis theta column mix sharing one xtime unit across cycles.
// Define THETA_DUAL_XTIME_EN for two chained xtime units (merged XT state).
module anubis_theta_seq #(
  parameter logic [7:0] POLY = 8'h1D
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data_out,
  output logic        busy
);

`ifdef THETA_DUAL_XTIME_EN
  typedef enum logic [1:0] {
    IDLE, XT, MIX, DONE
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, X2, X4, MIX, DONE
  } state_t;
`endif

  state_t      state_q, state_d;
  logic [1:0]  idx_q;
  logic [7:0]  a_q  [4];
  logic [7:0]  x2_q [4];
  logic [7:0]  x4_q [4];
  logic [7:0]  x6   [4];
  logic [7:0]  xt_in, xt1, xt2;
  logic [31:0] mix;

  function automatic logic [7:0] xtime(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? POLY : 8'h00);
  endfunction

`ifdef THETA_DUAL_XTIME_EN
  assign xt_in = a_q[idx_q];
  assign xt2   = xtime(xt1);
`else
  assign xt_in = (state_q == X4) ? x2_q[idx_q] : a_q[idx_q];
  assign xt2   = 8'h00;
`endif
  assign xt1 = xtime(xt_in);

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      x6[i] = x4_q[i] ^ x2_q[i];
    end
  end

  // b_j = sum_i a_i * h[i^j], h = {01,02,04,06}
  assign mix = {
    a_q[0]  ^ x2_q[1] ^ x4_q[2] ^ x6[3],
    x2_q[0] ^ a_q[1]  ^ x6[2]   ^ x4_q[3],
    x4_q[0] ^ x6[1]   ^ a_q[2]  ^ x2_q[3],
    x6[0]   ^ x4_q[1] ^ x2_q[2] ^ a_q[3]
  };

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
`ifdef THETA_DUAL_XTIME_EN
        state_d = XT;
`else
        state_d = X2;
`endif
      end
`ifdef THETA_DUAL_XTIME_EN
      XT: if (idx_q == 2'd3) state_d = MIX;
`else
      X2: if (idx_q == 2'd3) state_d = X4;
      X4: if (idx_q == 2'd3) state_d = MIX;
`endif
      MIX:  state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q    <= 2'd0;
      data_out <= 32'h0;
      for (int i = 0; i < 4; i++) begin
        a_q[i]  <= 8'h00;
        x2_q[i] <= 8'h00;
        x4_q[i] <= 8'h00;
      end
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          a_q[0] <= data_in[31:24];
          a_q[1] <= data_in[23:16];
          a_q[2] <= data_in[15:8];
          a_q[3] <= data_in[7:0];
          idx_q  <= 2'd0;
        end
`ifdef THETA_DUAL_XTIME_EN
        XT: begin
          x2_q[idx_q] <= xt1;
          x4_q[idx_q] <= xt2;
          idx_q       <= idx_q + 2'd1;
        end
`else
        X2: begin
          x2_q[idx_q] <= xt1;
          idx_q       <= idx_q + 2'd1;
        end
        X4: begin
          x4_q[idx_q] <= xt1;
          if (idx_q != 2'd3) idx_q <= idx_q + 2'd1;
        end
`endif
        MIX: data_out <= mix;
        default: ;
      endcase
    end
  end

endmodule
